// File: rtl/apb_transfer_fsm.sv
// APB master transfer FSM for the AHB-to-APB bridge.
// Accepts one request at a time from the AHB-side control and runs the
// IDLE -> SETUP -> ACCESS -> RESP sequence on the APB bus. The byte strobes
// come from the length code, and PREADY waits are bounded by a timeout.
// Each transfer ends with a one-cycle response pulse.
module apb_transfer_fsm #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        SIGNAL_LENGTH,
    output logic              req_ready,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    output logic [3:0]        PSTRB,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [31:0]       PRDATA,
    output logic              resp_valid,
    output logic              resp_err,
    output logic              resp_timeout,
    output logic [31:0]       resp_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The last ACCESS cycle allowed with PREADY low. Reaching it without
    // PREADY aborts the transfer, so at most TIMEOUT ACCESS cycles are spent.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [3:0]        pstrb_q, pstrb_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              resp_timeout_q, resp_timeout_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    // Convert the length code into byte strobes. Unknown codes fall back to a
    // single byte, and reads never assert strobes.
    function automatic logic [3:0] len_to_strb(input logic wr, input logic [3:0] len);
        logic [3:0] s;
        if (!wr) begin
            s = 4'b0000;
        end else begin
            case (len)
                4'b0001: s = 4'b0001;
                4'b0010: s = 4'b0011;
                4'b0100: s = 4'b1111;
                default: s = 4'b0001;
            endcase
        end
        return s;
    endfunction

    assign req_ready = (state_q == IDLE) && !HRESET;

    // Next-state and next-output logic for the transfer sequence.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        psel_d         = psel_q;
        penable_d      = penable_q;
        pwrite_d       = pwrite_q;
        paddr_d        = paddr_q;
        pwdata_d       = pwdata_q;
        pstrb_d        = pstrb_q;
        resp_valid_d   = 1'b0;
        resp_err_d     = resp_err_q;
        resp_timeout_d = resp_timeout_q;
        resp_rdata_d   = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    // Capture the request once. Later changes on req_* are
                    // ignored until the next acceptance.
                    paddr_d    = req_addr;
                    pwrite_d   = req_write;
                    pwdata_d   = req_wdata;
                    pstrb_d    = len_to_strb(req_write, SIGNAL_LENGTH);
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    wait_cnt_d = 8'd0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    resp_valid_d   = 1'b1;
                    resp_err_d     = PSLVERR;
                    resp_timeout_d = 1'b0;
                    resp_rdata_d   = pwrite_q ? 32'd0 : PRDATA;
                    psel_d         = 1'b0;
                    penable_d      = 1'b0;
                    state_d        = RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // The slave never answered in time. PSLVERR is ignored
                    // here because PREADY is low.
                    resp_valid_d   = 1'b1;
                    resp_err_d     = 1'b1;
                    resp_timeout_d = 1'b1;
                    resp_rdata_d   = 32'd0;
                    psel_d         = 1'b0;
                    penable_d      = 1'b0;
                    state_d        = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset also aborts any transfer in progress
    // without issuing a response.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q        <= IDLE;
            wait_cnt_q     <= 8'd0;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            paddr_q        <= '0;
            pwdata_q       <= 32'd0;
            pstrb_q        <= 4'b0000;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_rdata_q   <= 32'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            psel_q         <= psel_d;
            penable_q      <= penable_d;
            pwrite_q       <= pwrite_d;
            paddr_q        <= paddr_d;
            pwdata_q       <= pwdata_d;
            pstrb_q        <= pstrb_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_timeout_q <= resp_timeout_d;
            resp_rdata_q   <= resp_rdata_d;
        end
    end

    assign PSEL         = psel_q;
    assign PENABLE      = penable_q;
    assign PWRITE       = pwrite_q;
    assign PADDR        = paddr_q;
    assign PWDATA       = pwdata_q;
    assign PSTRB        = pstrb_q;
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_timeout = resp_timeout_q;
    assign resp_rdata   = resp_rdata_q;

endmodule

// File: tb/tb_apb_transfer_fsm.sv
// Bench for apb_transfer_fsm: table of directed transfers, randomized
// transfers against a reference model, and a reset-during-ACCESS sequence.
module tb_apb_transfer_fsm;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        SIGNAL_LENGTH;
    logic              req_ready;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [3:0]        PSTRB;
    logic              PREADY;
    logic              PSLVERR;
    logic [31:0]       PRDATA;
    logic              resp_valid;
    logic              resp_err;
    logic              resp_timeout;
    logic [31:0]       resp_rdata;

    apb_transfer_fsm #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .SIGNAL_LENGTH(SIGNAL_LENGTH), .req_ready(req_ready),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .PRDATA(PRDATA), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_timeout(resp_timeout), .resp_rdata(resp_rdata)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  len;
        int          waitc;    // PREADY low for this many ACCESS cycles
        bit          slverr;
        logic [31:0] prdata;
        logic [3:0]  e_strb;
        bit          e_err;
        bit          e_to;
        logic [31:0] e_rdata;
        int          e_acc;    // expected number of ACCESS cycles
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: the transfer's outcome from the rules on length codes,
    // slave errors and the wait bound.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (!v.wr) r.e_strb = 4'h0;
        else if (v.len == 4'd2) r.e_strb = 4'h3;
        else if (v.len == 4'd4) r.e_strb = 4'hF;
        else r.e_strb = 4'h1;
        r.e_to    = (v.waitc >= TIMEOUT);
        r.e_err   = r.e_to || v.slverr;
        r.e_rdata = (r.e_to || v.wr) ? 32'd0 : v.prdata;
        r.e_acc   = r.e_to ? TIMEOUT : v.waitc + 1;
        return r;
    endfunction

    // Runs one transfer; entered and left at a negedge with req_ready expected high.
    task automatic run_txn(input vec_t v, input string tag);
        int acc;
        check({tag, " req_ready before"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
        req_wdata = v.wdata; SIGNAL_LENGTH = v.len;
        @(posedge HCLK); #1;
        // Keep requesting with junk: must be ignored outside IDLE.
        req_write = ~v.wr; req_addr = $urandom; req_wdata = $urandom;
        SIGNAL_LENGTH = 4'($urandom);
        @(negedge HCLK);
        check({tag, " setup psel"}, {31'd0, PSEL}, 32'd1);
        check({tag, " setup penable"}, {31'd0, PENABLE}, 32'd0);
        check({tag, " paddr"}, PADDR, v.addr);
        check({tag, " pwrite"}, {31'd0, PWRITE}, {31'd0, v.wr});
        check({tag, " pwdata"}, PWDATA, v.wdata);
        check({tag, " pstrb"}, {28'd0, PSTRB}, {28'd0, v.e_strb});
        @(posedge HCLK);
        acc = 0;
        forever begin
            @(negedge HCLK);
            if (!(PSEL && PENABLE)) break;
            if (PADDR !== v.addr || PWDATA !== v.wdata || PSTRB !== v.e_strb)
                check({tag, " access stable paddr"}, PADDR, v.addr);
            acc++;
            if (acc > 300) begin
                check({tag, " access bound"}, acc, v.e_acc);
                break;
            end
            PREADY  = (acc - 1 == v.waitc);
            PSLVERR = PREADY ? v.slverr : 1'($urandom);
            PRDATA  = PREADY ? v.prdata : $urandom;
            @(posedge HCLK);
        end
        PREADY = 1'b0; PSLVERR = 1'b0; req_valid = 1'b0;
        check({tag, " access cycles"}, acc, v.e_acc);
        check({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, " resp_err"}, {31'd0, resp_err}, {31'd0, v.e_err});
        check({tag, " resp_timeout"}, {31'd0, resp_timeout}, {31'd0, v.e_to});
        check({tag, " resp_rdata"}, resp_rdata, v.e_rdata);
        check({tag, " psel in resp"}, {31'd0, PSEL}, 32'd0);
        check({tag, " req_ready in resp"}, {31'd0, req_ready}, 32'd0);
        @(negedge HCLK);
        check({tag, " resp_valid one cycle"}, {31'd0, resp_valid}, 32'd0);
        check({tag, " resp_err holds"}, {31'd0, resp_err}, {31'd0, v.e_err});
        check({tag, " req_ready N+4"}, {31'd0, req_ready}, 32'd1);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        //        wr   addr          wdata          len   wait sle prdata         strb  err to  rdata          acc
        tbl[0] = '{1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h4, 0,   0, 32'h0,         4'hF, 0, 0, 32'h0,         1};
        tbl[1] = '{1, 32'h0000_0020, 32'hFFFF_FF5A, 4'h1, 0,   0, 32'hAAAA_5555, 4'h1, 0, 0, 32'h0,         1};
        tbl[2] = '{1, 32'h0000_0024, 32'hFFFF_1234, 4'h2, 0,   0, 32'h0,         4'h3, 0, 0, 32'h0,         1};
        tbl[3] = '{1, 32'h0000_0028, 32'hFFFF_1234, 4'h7, 1,   0, 32'h0,         4'h1, 0, 0, 32'h0,         2};
        tbl[4] = '{0, 32'h0000_0040, 32'h0BAD_F00D, 4'h4, 3,   0, 32'h1234_5678, 4'h0, 0, 0, 32'h1234_5678, 4};
        tbl[5] = '{1, 32'h0000_0044, 32'h0000_0001, 4'h4, 0,   1, 32'h0,         4'hF, 1, 0, 32'h0,         1};
        tbl[6] = '{0, 32'h0000_0048, 32'h0,         4'h4, 99,  1, 32'h5555_AAAA, 4'h0, 1, 1, 32'h0,         16};

        HRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; SIGNAL_LENGTH = 4'h0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("reset req_ready", {31'd0, req_ready}, 32'd0);
        check("reset psel", {31'd0, PSEL}, 32'd0);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset outputs", {PADDR[15:0], PWDATA[7:0], 3'd0, PSTRB, PENABLE}, 32'd0);
        HRESET = 1'b0;
        #1;
        check("req_ready after reset", {31'd0, req_ready}, 32'd1);
        @(negedge HCLK);

        for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            rv.wr     = 1'($urandom);
            rv.addr   = $urandom;
            rv.wdata  = $urandom;
            rv.len    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 2));
            rv.waitc  = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
            rv.slverr = 1'($urandom);
            rv.prdata = $urandom;
            run_txn(model(rv), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of ACCESS: bus released, no response.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0080;
        req_wdata = 32'hCAFE_F00D; SIGNAL_LENGTH = 4'h4;
        @(posedge HCLK); #1 req_valid = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        check("rst seq penable", {31'd0, PENABLE}, 32'd1);
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        check("rst seq psel", {31'd0, PSEL}, 32'd0);
        check("rst seq penable drop", {31'd0, PENABLE}, 32'd0);
        check("rst seq resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst seq paddr", PADDR, 32'd0);
        check("rst seq pwdata", PWDATA, 32'd0);
        check("rst seq pstrb", {28'd0, PSTRB}, 32'd0);
        check("rst seq req_ready", {31'd0, req_ready}, 32'd0);
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rst seq req_ready after", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            check("rst seq no resp", {30'd0, resp_valid, PSEL}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
